// File: rtl/booth_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | booth_pkg : shared types and sizing helpers for the Booth sequencer |
// | Revision  : 1.0                                                    |
// +-------------------------------------------------------------------+
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    STG1 = 3'd2,
    STG2 = 3'd3,
    CAPT = 3'd4,
    DONE = 3'd5
  } state_e;

  // Radix-4 retires two multiplier bits per step.
  function automatic int iterations(input int in_width);
    return in_width / 2;
  endfunction

  function automatic int cnt_width(input int in_width);
    return (in_width / 2 > 1) ? $clog2(in_width / 2) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | booth_mult_ctrl : job sequencer for the 2-stage radix-4 Booth       |
// |                   multiplier datapath (load / enInp / enP strobes) |
// | Revision        : 1.0                                              |
// +-------------------------------------------------------------------+
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_multiplicand,
  input  logic [INPUT_WIDTH-1:0]  in_multiplier,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_product,
  output logic                    busy,
  output logic                    dp_load,
  output logic                    dp_en_inp,
  output logic                    dp_en_p,
  output logic [INPUT_WIDTH-1:0]  dp_multiplicand,
  output logic [INPUT_WIDTH-1:0]  dp_multiplier,
  input  logic [OUTPUT_WIDTH-1:0] dp_product
);

  localparam int ITERATIONS = iterations(INPUT_WIDTH);
  localparam int CNT_WIDTH  = cnt_width(INPUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ITERATIONS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] product_q, product_d;
  logic [INPUT_WIDTH-1:0]  mcand_q, mcand_d;
  logic [INPUT_WIDTH-1:0]  mplier_q, mplier_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    in_ready    = 1'b0;
    dp_load     = 1'b0;
    dp_en_inp   = 1'b0;
    dp_en_p     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = in_multiplicand;
          mplier_d = in_multiplier;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        dp_load = 1'b1;
        state_d = STG1;
      end
      STG1: begin
        dp_en_inp = 1'b1;
        state_d   = STG2;
      end
      // Stage 2 only ever follows stage 1, so enP always has fresh enInp data.
      STG2: begin
        dp_en_p = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = STG1;
        end
      end
      CAPT: begin
        product_d   = dp_product;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign out_valid       = out_valid_q;
  assign out_product     = product_q;
  assign dp_multiplicand = mcand_q;
  assign dp_multiplier   = mplier_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_booth_mult_ctrl : bench for booth_mult_ctrl with a behavioural   |
// |                      radix-4 datapath and a job-timeline model      |
// | Revision           : 1.0                                           |
// +-------------------------------------------------------------------+
module tb_booth_mult_ctrl;

  localparam int IW = 6;
  localparam int OW = 12;
  localparam int IT = IW / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] in_a = '0;
  logic [IW-1:0] in_b = '0;
  logic          in_ready, out_valid, busy, dp_load, dp_en_inp, dp_en_p;
  logic [OW-1:0] out_product, dp_product;
  logic [IW-1:0] dp_a, dp_b;

  booth_mult_ctrl #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_multiplicand (in_a),
    .in_multiplier   (in_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_product     (out_product),
    .busy            (busy),
    .dp_load         (dp_load),
    .dp_en_inp       (dp_en_inp),
    .dp_en_p         (dp_en_p),
    .dp_multiplicand (dp_a),
    .dp_multiplier   (dp_b),
    .dp_product      (dp_product)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural radix-4 Booth datapath ----------------
  int dp_acc = 0, dp_stage = 0, dp_step = 0;

  function automatic int booth_digit(input logic [IW-1:0] b, input int s);
    int lo, mid, hi;
    if (s < 0 || s >= IT) return 0;
    lo  = (s == 0) ? 0 : int'(b[2*s-1]);
    mid = int'(b[2*s]);
    hi  = int'(b[2*s+1]);
    return -2 * hi + mid + lo;
  endfunction

  always @(posedge clk) begin
    if (dp_load) begin
      dp_acc  <= 0;
      dp_step <= 0;
    end else if (dp_en_inp) begin
      dp_stage <= booth_digit(dp_b, dp_step) * int'($signed(dp_a)) * (1 << (2 * dp_step));
    end else if (dp_en_p) begin
      dp_acc  <= dp_acc + dp_stage;
      dp_step <= dp_step + 1;
    end
  end
  assign dp_product = dp_acc[OW-1:0];

  // ---------------- job timeline model ----------------
  // m_k counts cycles since the accepting edge: 0 load, odd enInp, even enP,
  // 2*IT+1 capture, 2*IT+2 product presented until taken.
  bit            m_act = 1'b0;
  int            m_k = 0;
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_prod = '0;
  logic [IW-1:0] m_a = '0, m_b = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_k <= 0; m_valid <= 1'b0; m_prod <= '0; m_a <= '0; m_b <= '0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act <= 1'b1; m_k <= 0; m_a <= in_a; m_b <= in_b;
      end
    end else if (m_k == 2*IT+2) begin
      if (out_ready) begin
        m_act <= 1'b0; m_valid <= 1'b0;
      end
    end else begin
      if (m_k == 2*IT+1) begin
        m_valid <= 1'b1;
        m_prod  <= OW'(int'($signed(m_a)) * int'($signed(m_b)));
      end
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] exp_ctl;
      exp_ctl[5] = !m_act;
      exp_ctl[4] = m_act;
      exp_ctl[3] = m_act && (m_k == 0);
      exp_ctl[2] = m_act && (m_k % 2 == 1) && (m_k <= 2*IT-1);
      exp_ctl[1] = m_act && (m_k % 2 == 0) && (m_k >= 2) && (m_k <= 2*IT);
      exp_ctl[0] = m_valid;
      check("cyc_ctl{rdy,busy,ld,inp,p,vld}",
            32'({in_ready, busy, dp_load, dp_en_inp, dp_en_p, out_valid}), 32'(exp_ctl));
      check("cyc_product", 32'(out_product), 32'(m_prod));
      check("cyc_dp_operands", 32'({dp_a, dp_b}), 32'({m_a, m_b}));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_job(input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input int hold, input logic [OW-1:0] exp, input string name);
    string seq;
    int    lat;
    bit    seen;
    seq = ""; lat = 0; seen = 1'b0;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 30 && !seen; n++) begin
      if (dp_load)   seq = {seq, "L"};
      if (dp_en_inp) seq = {seq, "I"};
      if (dp_en_p)   seq = {seq, "P"};
      if (out_valid) begin
        seen = 1'b1; lat = n;
      end else begin
        in_a = IW'($urandom); in_b = IW'($urandom);
        @(negedge clk);
      end
    end
    check({name, "_seen_out_valid"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(2*IT+3));
    n_tests++;
    if (seq != "LIPIPIP") begin
      n_fail++;
      $display("FAIL %s_strobes: got %s expected LIPIPIP", name, seq);
    end
    check({name, "_product"}, 32'(out_product), 32'(exp));
    check({name, "_dp_ops_held"}, 32'({dp_a, dp_b}), 32'({a, b}));
    for (int i = 0; i < hold; i++) begin
      check({name, "_bp_valid"}, 32'(out_valid), 32'd1);
      check({name, "_bp_product"}, 32'(out_product), 32'(exp));
      check({name, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      in_valid = (i == 1);
      in_a = 6'd9; in_b = 6'd9;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_release_valid"}, 32'(out_valid), 32'd0);
    check({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ctl", 32'({in_ready, busy, dp_load, dp_en_inp, dp_en_p, out_valid}), 32'b100000);
    check("reset_product", 32'(out_product), 32'd0);
    check("reset_dp_operands", 32'({dp_a, dp_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job(6'd3,       6'(-2),  0, 12'hFFA, "3x-2");
    run_job(6'(-32),    6'(-32), 0, 12'h400, "-32x-32");
    run_job(6'd31,      6'(-32), 0, 12'hC20, "31x-32");
    run_job(6'd0,       6'd17,   0, 12'h000, "0x17");
    run_job(6'd7,       6'(-5),  5, 12'hFDD, "backpressure_7x-5");

    // Back-to-back with in_valid held: each job spends one cycle in every state
    // IDLE..DONE plus the extra stage pairs, so valid pulses are ten cycles apart.
    begin
      bit got1, got2, pv;
      int t1, t2;
      logic [OW-1:0] p1, p2;
      got1 = 0; got2 = 0; pv = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 6'd5; in_b = 6'd7;
      @(negedge clk);
      in_a = 6'(-6); in_b = 6'd9;
      for (int n = 1; n <= 40 && !got2; n++) begin
        if (out_valid && !pv) begin
          if (!got1) begin got1 = 1; t1 = n; p1 = out_product; end
          else begin got2 = 1; t2 = n; p2 = out_product; end
        end
        pv = out_valid;
        if (got1 && !out_valid && busy) in_valid = 1'b0;
        if (!got2) @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_first_product", 32'(p1), 32'h023);
      check("b2b_second_product", 32'(p2), 32'hFCA);
      check("b2b_spacing", 32'(t2 - t1), 32'd10);
      @(negedge clk);
      check("b2b_idle_after", 32'({in_ready, busy}), 32'b10);
    end

    // Reset during the second stage-1 cycle drops the job.
    in_valid = 1'b1; in_a = 6'd3; in_b = 6'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_second_stg1", 32'({dp_en_inp, dp_en_p, dp_load}), 32'b100);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", 32'({in_ready, busy, dp_load, dp_en_inp, dp_en_p, out_valid}), 32'b100000);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_job(6'd4, 6'd4, 0, 12'h010, "4x4_after_rst");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
